// File: rtl/uart_prog_loader.sv
// Serial program loader: receives 8N1 bytes, writes them to RAM from BASE_ADDR
// upward and holds the CPU in reset until the line has been idle long enough.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter logic [15:0] BASE_ADDR    = 16'h0600,
  parameter int unsigned IDLE_BITS    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        serial_rxd,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic [15:0] byte_count,
  output logic        frame_err
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {LD_RUN, LD_LOAD} ld_state_e;

  rx_state_e          rx_state_q, rx_state_d;
  ld_state_e          ld_state_q, ld_state_d;
  logic               rx_s1_q, rx_s1_d;
  logic               rx_s2_q, rx_s2_d;
  logic               wait_high_q, wait_high_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0]        next_addr_q, next_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic [15:0]        byte_count_q, byte_count_d;
  logic               frame_err_q, frame_err_d;
  logic               byte_valid;
  logic               start_entry;

  // Next-state logic for the receiver, loader and idle timer
  always_comb begin
    rx_s1_d      = serial_rxd;
    rx_s2_d      = rx_s1_q;
    rx_state_d   = rx_state_q;
    ld_state_d   = ld_state_q;
    wait_high_d  = wait_high_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    next_addr_d  = next_addr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    byte_count_d = byte_count_q;
    frame_err_d  = 1'b0;
    byte_valid   = 1'b0;
    start_entry  = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        // After a framing error the line must go high before a new start is accepted
        if (rx_s2_q) begin
          wait_high_d = 1'b0;
        end else if (!wait_high_q) begin
          start_entry = 1'b1;
          rx_state_d  = RX_START;
          clk_cnt_d   = '0;
          bit_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_cnt_d  = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            byte_valid = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Loader: a byte in RUN starts a fresh load at BASE_ADDR
    if (byte_valid) begin
      mem_we_d    = 1'b1;
      mem_wdata_d = shift_q;
      idle_cnt_d  = '0;
      ld_state_d  = LD_LOAD;
      cpu_hold_d  = 1'b1;
      if (ld_state_q == LD_RUN) begin
        mem_addr_d   = BASE_ADDR;
        next_addr_d  = BASE_ADDR + 16'd1;
        byte_count_d = 16'd1;
      end else begin
        mem_addr_d  = next_addr_q;
        next_addr_d = next_addr_q + 16'd1;
        if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
      end
    end else if (start_entry || ld_state_q == LD_RUN) begin
      idle_cnt_d = '0;
    end else if (rx_state_q == RX_IDLE) begin
      if (idle_cnt_q == IDLE_W'(IDLE_MAX - 1)) begin
        idle_cnt_d = '0;
        ld_state_d = LD_RUN;
        cpu_hold_d = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      ld_state_q   <= LD_RUN;
      wait_high_q  <= 1'b0;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_cnt_q   <= '0;
      next_addr_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      byte_count_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_state_q   <= rx_state_d;
      ld_state_q   <= ld_state_d;
      wait_high_q  <= wait_high_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_cnt_q   <= idle_cnt_d;
      next_addr_q  <= next_addr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      byte_count_q <= byte_count_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign byte_count = byte_count_q;
  assign frame_err  = frame_err_q;

endmodule
